// File: rtl/psram_arbiter.sv
// psram_arbiter: shares the asynchronous cellular RAM between the video fetch
// port (read-only, priority) and the game-logic port (read/write). Each access
// is IDLE -> ACCESS (RD_WAIT/WR_WAIT cycles of low strobes) -> RECOVER (ack).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   vid_req/vid_addr             video read request and address
//   vid_ack/vid_rdata            one-cycle ack with read data
//   gm_req/gm_we/gm_addr/
//   gm_wdata/gm_be               game request, direction, address, data, byte enables
//   gm_ack/gm_rdata              one-cycle ack with read data
//   MemAdr/MemDB                 RAM address and bidirectional data bus
//   we_L/oe_L/ce_L/lb_L/ub_L     active-low RAM strobes
//   RamADV_L/RamCLK/RamCRE/FlashCS  static async-mode pins
module psram_arbiter #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned RD_WAIT    = 4,
  parameter int unsigned WR_WAIT    = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [15:0]       vid_rdata,
  input  logic              gm_req,
  input  logic              gm_we,
  input  logic [ADDR_W-1:0] gm_addr,
  input  logic [15:0]       gm_wdata,
  input  logic [1:0]        gm_be,
  output logic              gm_ack,
  output logic [15:0]       gm_rdata,
  output logic [ADDR_W-1:0] MemAdr,
  inout  wire  [15:0]       MemDB,
  output logic              we_L,
  output logic              oe_L,
  output logic              ce_L,
  output logic              lb_L,
  output logic              ub_L,
  output logic              RamADV_L,
  output logic              RamCLK,
  output logic              RamCRE,
  output logic              FlashCS
);

  localparam int unsigned MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
  localparam int unsigned CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int unsigned SW       = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [SW-1:0]       r_starve, w_starve;
  logic                r_is_vid, w_is_vid;
  logic                r_we, w_we;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [15:0]         r_wdata, w_wdata;
  logic [1:0]          r_be, w_be;
  logic                r_drive, w_drive;
  logic                r_ce_L, w_ce_L, r_oe_L, w_oe_L, r_we_L, w_we_L;
  logic                r_lb_L, w_lb_L, r_ub_L, w_ub_L;
  logic                r_vid_ack, w_vid_ack, r_gm_ack, w_gm_ack;
  logic [15:0]         r_vid_rdata, w_vid_rdata, r_gm_rdata, w_gm_rdata;
  logic                w_grant_vid;
  logic                w_in_acc;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_starve    <= '0;
      r_is_vid    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_drive     <= 1'b0;
      r_ce_L      <= 1'b1;
      r_oe_L      <= 1'b1;
      r_we_L      <= 1'b1;
      r_lb_L      <= 1'b1;
      r_ub_L      <= 1'b1;
      r_vid_ack   <= 1'b0;
      r_gm_ack    <= 1'b0;
      r_vid_rdata <= '0;
      r_gm_rdata  <= '0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_starve    <= w_starve;
      r_is_vid    <= w_is_vid;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_be        <= w_be;
      r_drive     <= w_drive;
      r_ce_L      <= w_ce_L;
      r_oe_L      <= w_oe_L;
      r_we_L      <= w_we_L;
      r_lb_L      <= w_lb_L;
      r_ub_L      <= w_ub_L;
      r_vid_ack   <= w_vid_ack;
      r_gm_ack    <= w_gm_ack;
      r_vid_rdata <= w_vid_rdata;
      r_gm_rdata  <= w_gm_rdata;
    end
  end

  // Next-state, arbitration and strobe generation
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_starve    = r_starve;
    w_is_vid    = r_is_vid;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_be        = r_be;
    w_vid_ack   = 1'b0;
    w_gm_ack    = 1'b0;
    w_vid_rdata = r_vid_rdata;
    w_gm_rdata  = r_gm_rdata;
    // Video wins unless the game port has already been passed over STARVE_MAX times
    w_grant_vid = vid_req && !(gm_req && (r_starve == SW'(STARVE_MAX)));

    case (r_state)
      S_IDLE: begin
        if (vid_req || gm_req) begin
          w_state  = S_ACCESS;
          w_is_vid = w_grant_vid;
          if (w_grant_vid) begin
            w_we   = 1'b0;
            w_addr = vid_addr;
            w_be   = 2'b11;
            w_cnt  = CNT_W'(RD_WAIT - 1);
            if (gm_req && (r_starve != SW'(STARVE_MAX)))
              w_starve = r_starve + SW'(1);
          end else begin
            w_we     = gm_we;
            w_addr   = gm_addr;
            w_wdata  = gm_wdata;
            w_be     = gm_be;
            w_cnt    = gm_we ? CNT_W'(WR_WAIT - 1) : CNT_W'(RD_WAIT - 1);
            w_starve = '0;
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          // Last strobe cycle: capture read data on the closing edge
          w_state   = S_RECOVER;
          w_vid_ack = r_is_vid;
          w_gm_ack  = !r_is_vid;
          if (!r_we) begin
            if (r_is_vid) w_vid_rdata = MemDB;
            else          w_gm_rdata  = MemDB;
          end
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_RECOVER: w_state = S_IDLE;
      default:   w_state = S_IDLE;
    endcase

    // Strobes are a function of the state being entered and the latched request
    w_in_acc = (w_state == S_ACCESS);
    w_ce_L   = !w_in_acc;
    w_oe_L   = !(w_in_acc && !w_we);
    w_we_L   = !(w_in_acc && w_we && (w_be != 2'b00));
    w_lb_L   = !(w_in_acc && (!w_we || w_be[0]));
    w_ub_L   = !(w_in_acc && (!w_we || w_be[1]));
    w_drive  = w_in_acc && w_we;
  end

  assign MemDB     = r_drive ? r_wdata : 16'bz;
  assign MemAdr    = r_addr;
  assign ce_L      = r_ce_L;
  assign oe_L      = r_oe_L;
  assign we_L      = r_we_L;
  assign lb_L      = r_lb_L;
  assign ub_L      = r_ub_L;
  assign vid_ack   = r_vid_ack;
  assign gm_ack    = r_gm_ack;
  assign vid_rdata = r_vid_rdata;
  assign gm_rdata  = r_gm_rdata;

  // Asynchronous-mode configuration pins
  assign RamADV_L  = 1'b0;
  assign RamCLK    = 1'b0;
  assign RamCRE    = 1'b0;
  assign FlashCS   = 1'b1;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: a slot-level reference model predicts
// grants, strobe windows, ack times and read data; a negedge monitor compares.
module tb_psram_arbiter;
  localparam int unsigned ADDR_W     = 26;
  localparam int unsigned RD_WAIT    = 4;
  localparam int unsigned WR_WAIT    = 4;
  localparam int unsigned STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst;
  logic vid_req, gm_req, gm_we;
  logic [ADDR_W-1:0] vid_addr, gm_addr, MemAdr;
  logic [15:0] gm_wdata, vid_rdata, gm_rdata;
  logic [1:0]  gm_be;
  logic vid_ack, gm_ack, we_L, oe_L, ce_L, lb_L, ub_L;
  logic RamADV_L, RamCLK, RamCRE, FlashCS;
  wire  [15:0] MemDB;

  always #5 clk = ~clk;

  psram_arbiter #(.ADDR_W(ADDR_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT),
                  .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .gm_req(gm_req), .gm_we(gm_we), .gm_addr(gm_addr), .gm_wdata(gm_wdata),
    .gm_be(gm_be), .gm_ack(gm_ack), .gm_rdata(gm_rdata),
    .MemAdr(MemAdr), .MemDB(MemDB),
    .we_L(we_L), .oe_L(oe_L), .ce_L(ce_L), .lb_L(lb_L), .ub_L(ub_L),
    .RamADV_L(RamADV_L), .RamCLK(RamCLK), .RamCRE(RamCRE), .FlashCS(FlashCS)
  );

  int unsigned n_checks = 0, n_pass = 0;
  int unsigned e = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, e);
  endtask

  // ---------------- RAM model (the board device) ----------------
  logic [15:0] ram_mem [logic [ADDR_W-1:0]];
  logic [15:0] ref_mem [logic [ADDR_W-1:0]];
  logic [15:0] ram_rd = 16'h0;

  function automatic logic [15:0] dflt(input logic [ADDR_W-1:0] a);
    return 16'(a * 26'd40503) ^ 16'hC3A5;
  endfunction
  function automatic logic [15:0] ram_read(input logic [ADDR_W-1:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : dflt(a);
  endfunction
  function automatic logic [15:0] ref_read(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  assign MemDB = (!oe_L && !ce_L) ? ram_rd : 16'bz;
  always @(negedge clk) ram_rd <= ram_read(MemAdr);

  always @(posedge clk) begin : ram_write
    logic [15:0] w;
    if (!ce_L && !we_L) begin
      w = ram_read(MemAdr);
      if (!lb_L) w[7:0]  = MemDB[7:0];
      if (!ub_L) w[15:8] = MemDB[15:8];
      ram_mem[MemAdr] = w;
    end
  end

  // ---------------- Reference model: slot arithmetic ----------------
  typedef struct { int unsigned ack_edge; logic [15:0] rdata; } exp_t;
  exp_t vq[$], gq[$];
  bit model_ready = 1'b0;
  bit cur_valid = 1'b0, cur_we = 1'b0;
  logic [1:0] cur_be = 2'b00;
  logic [ADDR_W-1:0] cur_addr = '0, exp_adr = '0;
  logic [15:0] cur_wdata = '0, v_last = '0, g_last = '0;
  int unsigned cur_start = 0, cur_end = 0, cur_ack = 0, free_at = 0, starve = 0;

  always @(posedge clk) begin : model
    bit take_vid;
    int unsigned w;
    logic [15:0] old;
    e = e + 1;
    if (rst) begin
      model_ready = 1'b1; cur_valid = 1'b0; exp_adr = '0;
      vq.delete(); gq.delete();
      starve = 0; v_last = '0; g_last = '0; free_at = e + 1;
    end else if (model_ready) begin
      if (cur_valid && cur_we && e == cur_ack) begin
        old = ref_read(cur_addr);
        if (cur_be[0]) old[7:0]  = cur_wdata[7:0];
        if (cur_be[1]) old[15:8] = cur_wdata[15:8];
        ref_mem[cur_addr] = old;
      end
      if (e >= free_at && (vid_req || gm_req)) begin
        take_vid  = vid_req && !(gm_req && starve == STARVE_MAX);
        cur_we    = !take_vid && gm_we;
        w         = cur_we ? WR_WAIT : RD_WAIT;
        cur_valid = 1'b1; cur_start = e; cur_end = e + w - 1;
        cur_ack   = e + w; free_at = e + w + 2;
        cur_be    = take_vid ? 2'b11 : gm_be;
        cur_addr  = take_vid ? vid_addr : gm_addr;
        cur_wdata = gm_wdata;
        exp_adr   = cur_addr;
        if (take_vid) begin
          v_last = ref_read(vid_addr);
          vq.push_back('{cur_ack, v_last});
          if (gm_req && starve < STARVE_MAX) starve++;
        end else begin
          starve = 0;
          if (!gm_we) g_last = ref_read(gm_addr);
          gq.push_back('{cur_ack, g_last});
        end
      end
    end
  end

  // ---------------- Monitor ----------------
  logic [7:0] obs_bits = '0;

  always @(negedge clk) begin : monitor
    bit in_win;
    logic x_ce, x_oe, x_we, x_lb, x_ub;
    exp_t x;
    if (model_ready) begin
      in_win = cur_valid && (e >= cur_start) && (e <= cur_end);
      x_ce = !in_win;
      x_oe = !(in_win && !cur_we);
      x_we = !(in_win && cur_we && cur_be != 2'b00);
      x_lb = !(in_win && (!cur_we || cur_be[0]));
      x_ub = !(in_win && (!cur_we || cur_be[1]));
      check("strobes", 64'({ce_L, oe_L, we_L, lb_L, ub_L, RamADV_L, RamCLK, RamCRE, FlashCS}),
                       64'({x_ce, x_oe, x_we, x_lb, x_ub, 4'b0001}));
      check("MemAdr", 64'(MemAdr), 64'(exp_adr));
      if (!x_we) check("MemDB_write", 64'(MemDB), 64'(cur_wdata));
      check("ack_overlap", 64'(vid_ack & gm_ack), 64'(0));
      if (vid_ack || gm_ack) obs_bits = {obs_bits[6:0], vid_ack};
      if (vid_ack) begin
        if (vq.size() == 0) check("vid_ack_spurious", 64'(vid_ack), 64'(0));
        else begin
          x = vq.pop_front();
          check("vid_ack_edge", 64'(e), 64'(x.ack_edge));
          check("vid_rdata", 64'(vid_rdata), 64'(x.rdata));
        end
      end else if (vq.size() != 0 && vq[0].ack_edge < e) begin
        x = vq.pop_front();
        check("vid_ack_missing", 64'(vid_ack), 64'(1));
      end
      if (gm_ack) begin
        if (gq.size() == 0) check("gm_ack_spurious", 64'(gm_ack), 64'(0));
        else begin
          x = gq.pop_front();
          check("gm_ack_edge", 64'(e), 64'(x.ack_edge));
          check("gm_rdata", 64'(gm_rdata), 64'(x.rdata));
        end
      end else if (gq.size() != 0 && gq[0].ack_edge < e) begin
        x = gq.pop_front();
        check("gm_ack_missing", 64'(gm_ack), 64'(1));
      end
    end
  end

  // ---------------- Stimulus ----------------
  int unsigned v_left = 0, g_left = 0;
  bit rand_gaps = 1'b0;
  int unsigned cnt_oe_low, cnt_we_low, cnt_vack, cnt_gack;

  task automatic clr_counts();
    cnt_oe_low = 0; cnt_we_low = 0; cnt_vack = 0; cnt_gack = 0;
  endtask

  // Requesters drop req in their ack cycle, optionally re-requesting at once
  task automatic agents();
    if (vid_req && vid_ack) vid_req = 1'b0;
    if (gm_req && gm_ack)   gm_req  = 1'b0;
    if (!vid_req && v_left > 0 && (!rand_gaps || $urandom_range(0, 3) == 0)) begin
      vid_req  = 1'b1;
      vid_addr = ADDR_W'($urandom_range(0, 63));
      v_left--;
    end
    if (!gm_req && g_left > 0 && (!rand_gaps || $urandom_range(0, 3) == 0)) begin
      gm_req   = 1'b1;
      gm_we    = 1'($urandom_range(0, 1));
      gm_addr  = ADDR_W'($urandom_range(0, 63));
      gm_wdata = 16'($urandom);
      gm_be    = 2'($urandom_range(0, 3));
      g_left--;
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
    if (!oe_L && !ce_L) cnt_oe_low++;
    if (!we_L) cnt_we_low++;
    if (vid_ack) cnt_vack++;
    if (gm_ack)  cnt_gack++;
    agents();
  endtask

  task automatic run_quiet(input string name, input int unsigned budget);
    int unsigned n = 0;
    while ((v_left != 0 || g_left != 0 || vid_req || gm_req) && n < budget) begin
      tick(); n++;
    end
    if (n >= budget) check(name, 64'({vid_req, gm_req}), 64'(0));
    repeat (3) tick();
  endtask

  initial begin : stim
    int unsigned lat;
    bit found;
    rst = 1'b1; vid_req = 1'b0; gm_req = 1'b0; gm_we = 1'b0;
    vid_addr = '0; gm_addr = '0; gm_wdata = '0; gm_be = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_vid_rdata", 64'(vid_rdata), 64'(0));
    check("reset_gm_rdata", 64'(gm_rdata), 64'(0));

    // Video read of 0x123
    ram_mem[26'h123] = 16'hBEEF; ref_mem[26'h123] = 16'hBEEF;
    clr_counts();
    vid_req = 1'b1; vid_addr = 26'h123;
    run_quiet("vid_read_timeout", 20);
    check("vid_read_oe_cycles", 64'(cnt_oe_low), 64'(4));
    check("vid_read_we_cycles", 64'(cnt_we_low), 64'(0));
    check("vid_read_acks", 64'(cnt_vack), 64'(1));
    check("vid_read_data", 64'(vid_rdata), 64'(16'hBEEF));

    // Game lower-byte write then read-back
    ram_mem[26'h10] = 16'h1234; ref_mem[26'h10] = 16'h1234;
    clr_counts();
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 26'h10; gm_wdata = 16'hA55A; gm_be = 2'b01;
    run_quiet("gm_write_timeout", 20);
    check("gm_write_we_cycles", 64'(cnt_we_low), 64'(4));
    check("gm_write_acks", 64'(cnt_gack), 64'(1));
    check("gm_write_ram", 64'(ram_read(26'h10)), 64'(16'h125A));
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 26'h10;
    run_quiet("gm_read_timeout", 20);
    check("gm_readback", 64'(gm_rdata), 64'(16'h125A));

    // Continuous contention
    obs_bits = '0; rand_gaps = 1'b0; v_left = 6; g_left = 2;
    run_quiet("contention_timeout", 100);
    check("grant_order", 64'(obs_bits), 64'(8'b11101110));

    // Write with no byte enables
    ram_mem[26'h11] = 16'h7777; ref_mem[26'h11] = 16'h7777;
    clr_counts();
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 26'h11; gm_wdata = 16'hFFFF; gm_be = 2'b00;
    lat = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (gm_ack) begin lat = i; found = 1'b1; end
    end
    check("be00_ack_cycle", 64'(lat), 64'(5));
    check("be00_we_cycles", 64'(cnt_we_low), 64'(0));
    check("be00_ram", 64'(ram_read(26'h11)), 64'(16'h7777));
    repeat (3) tick();

    // Reset in the second ACCESS cycle of a write
    gm_req = 1'b1; gm_we = 1'b1; gm_addr = 26'h2000; gm_wdata = 16'h1357; gm_be = 2'b11;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (!we_L) found = 1'b1;
    end
    check("rst_write_started", 64'(found), 64'(1));
    tick();
    rst = 1'b1; gm_req = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_strobes", 64'({ce_L, oe_L, we_L, lb_L, ub_L}), 64'(5'h1F));
    check("rst_MemAdr", 64'(MemAdr), 64'(0));
    check("rst_gm_rdata", 64'(gm_rdata), 64'(0));
    clr_counts();
    repeat (10) tick();
    check("rst_no_ack", 64'(cnt_gack), 64'(0));
    clr_counts();
    gm_req = 1'b1; gm_we = 1'b0; gm_addr = 26'h10;
    run_quiet("post_rst_timeout", 20);
    check("post_rst_acks", 64'(cnt_gack), 64'(1));

    // Randomized traffic
    clr_counts();
    rand_gaps = 1'b1; v_left = 40; g_left = 40;
    run_quiet("random_timeout", 3000);
    check("random_vid_acks", 64'(cnt_vack), 64'(40));
    check("random_gm_acks", 64'(cnt_gack), 64'(40));

    repeat (5) tick();
    check("vid_queue_drained", 64'(vq.size()), 64'(0));
    check("gm_queue_drained", 64'(gq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the board's asynchronous cellular RAM between two requesters: the VGA pixel/frame fetch port (read-only, latency-critical) and the game-logic port (read/write: court, ball and sprite state).
- Generates asynchronous-mode SRAM strobes with programmable wait states and one recovery cycle.
- Returns read data through a one-cycle ack handshake.
- Sits between the video/game logic and the top-level RAM pins.

Parameters:
- ADDR_W, 26, width of MemAdr and both requester address buses.
- RD_WAIT, 4, clk cycles strobes are held low for a read (must be >= 1).
- WR_WAIT, 4, clk cycles strobes are held low for a write (must be >= 1).
- STARVE_MAX, 3, consecutive video grants allowed while a game request waits.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- vid_req  in  1  video read request; held high until vid_ack
- vid_addr  in  ADDR_W  video read address; stable while vid_req is high
- vid_ack  out  1  one-cycle pulse; vid_rdata valid in the same cycle
- vid_rdata  out  16  video read data
- gm_req  in  1  game request; held high until gm_ack
- gm_we  in  1  1 = write, 0 = read
- gm_addr  in  ADDR_W  game address
- gm_wdata  in  16  game write data
- gm_be  in  2  byte enables; bit1 = upper byte, bit0 = lower byte
- gm_ack  out  1  one-cycle completion pulse
- gm_rdata  out  16  game read data, valid with gm_ack
- MemAdr  out  ADDR_W  RAM address
- MemDB  inout  16  RAM data bus
- we_L, oe_L, ce_L, lb_L, ub_L  out  1 each  active-low RAM strobes
- RamADV_L, RamCLK, RamCRE, FlashCS  out  1 each  static RAM/flash mode pins

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - ce_L, oe_L, we_L, lb_L, ub_L = 1.
  - MemAdr = 0; MemDB tri-stated.
  - vid_ack = gm_ack = 0; vid_rdata = gm_rdata = 0; starve_cnt = 0.
- Static pins (async mode), at all times including reset: RamADV_L = 0, RamCLK = 0, RamCRE = 0, FlashCS = 1.
- States: IDLE -> ACCESS -> RECOVER -> IDLE.
- IDLE:
  - All strobes high; MemDB tri-stated.
  - At an edge with any request high, grant one requester. Latch address, direction, write data and byte enables. Load the wait counter with RD_WAIT-1 or WR_WAIT-1. Go to ACCESS.
- Arbitration:
  - Video wins a simultaneous request unless starve_cnt == STARVE_MAX; in that case the game port wins.
  - starve_cnt increments (saturating) on a video grant while gm_req is high.
  - starve_cnt clears on any game grant.
- ACCESS:
  - ce_L = 0 and MemAdr = latched address throughout.
  - Read: oe_L = 0, lb_L = ub_L = 0, MemDB tri-stated.
  - Write: we_L = 0, lb_L = ~be[0], ub_L = ~be[1], MemDB driven with latched data.
  - Counter decrements each cycle; leave ACCESS at the edge where it reads 0.
  - Read data is captured from MemDB at that edge into the granted port's rdata register.
- RECOVER (exactly 1 cycle):
  - All strobes high; MemDB tri-stated; MemAdr holds its value.
  - The granted port's ack = 1. Only one ack is ever high at a time.
- Latency and throughput:
  - Request sampled at edge N -> strobes low for cycles N+1..N+WAIT -> ack high in cycle N+WAIT+1.
  - Next grant is possible at edge N+WAIT+2, so peak throughput is one access per WAIT+2 cycles.
- Back-to-back: a requester whose req is still high in IDLE after its ack gets a new access. Requesters must drop req in the ack cycle if no further access is wanted.
- Write with gm_be = 00: full ACCESS timing, but we_L, lb_L and ub_L stay high; ack still issued.
- rdata registers hold their last value until the next read for that port; writes do not alter gm_rdata.
- Reset mid-operation: strobes return high and MemDB releases on the cycle after the rst edge. No ack is issued for the aborted access.
- A request change during ACCESS has no effect; inputs are latched at the grant.

Test Plan:
- Video read: RD_WAIT=4, vid_req with vid_addr=0x000123, RAM model returns 0xBEEF -> oe_L=ce_L=0 for exactly 4 cycles, MemAdr=0x000123, vid_ack one cycle later with vid_rdata=0xBEEF, we_L stays 1.
- Game byte write: gm_we=1, gm_addr=0x10, gm_wdata=0xA55A, gm_be=01 -> we_L=0 for 4 cycles, lb_L=0, ub_L=1, MemDB=0xA55A only while we_L=0, gm_ack 1 cycle later; model lower byte becomes 0x5A, upper byte unchanged.
- Contention: vid_req and gm_req held high continuously -> grant order V,V,V,G,V,V,V,G. Each access spans 6 cycles; acks never overlap.
- Reset during access: assert rst at the 2nd ACCESS cycle of a write -> the next cycle has all strobes 1, MemDB high-Z and MemAdr=0; no gm_ack; a fresh request afterwards completes normally.
- Static pins and empty enables: throughout the run RamADV_L=0, RamCLK=0, RamCRE=0, FlashCS=1. Write with gm_be=00 -> we_L never low, gm_ack still at cycle N+5.
